// File: rtl/nor_tree_pipe_pkg.sv
// Shared sizing helpers for pipelined reduction trees (OR/NOR now, AND/XOR
// trees later). All functions are constant functions, usable in localparams.
//   clog_fanin   : number of tree levels L, smallest L with fanin^L >= width
//   level_width  : bit count held by level k (level 0 is the input word)
//   level_offset : start bit of level k inside a flat concatenation of
//                  levels 0,1,2,... (used to chain levels without 2-D arrays)
package rv523_cell_pkg;

   localparam int MAX_LEVELS = 16;

   function automatic int clog_fanin(input int width, input int fanin);
      int    l;
      longint p;
      l = 0;
      p = 1;
      for (int i = 0; i < MAX_LEVELS; i++) begin
         if (p < longint'(width)) begin
            p = p * longint'(fanin);
            l = l + 1;
         end
      end
      return l;
   endfunction

   function automatic int level_width(input int width, input int fanin, input int k);
      int w;
      w = width;
      for (int i = 0; i < MAX_LEVELS; i++) begin
         if (i < k) w = (w + fanin - 1) / fanin;
      end
      return w;
   endfunction

   function automatic int level_offset(input int width, input int fanin, input int k);
      int off;
      off = 0;
      for (int i = 0; i <= MAX_LEVELS; i++) begin
         if (i < k) off = off + level_width(width, fanin, i);
      end
      return off;
   endfunction

endpackage

// File: rtl/nor_tree_pipe_if.sv
// Token bus of the NOR/OR reduction pipe.
//   in_valid/a/invert : one token per cycle; a token exists on a cycle with
//                       in_valid=1 and stall=0, and is never backpressured
//                       otherwise (no ready: a token offered while stall=1 is
//                       dropped, not queued).
//   stall             : freezes the whole pipe, including out_valid/y.
//   out_valid/y       : y carries a token result on a cycle with out_valid=1;
//                       y keeps its last result while out_valid=0.
interface nor_tree_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic             invert;
   logic             stall;
   logic             out_valid;
   logic             y;

   modport master (output in_valid, a, invert, stall, input out_valid, y);
   modport slave  (input in_valid, a, invert, stall, output out_valid, y);
endinterface

// File: rtl/nor_tree_level.sv
// One register rank of the reduction tree.
//   in_data  : IN_W bits from the previous level (or the input word)
//   out_data : ceil(IN_W/FANIN) bits, each the OR of one FANIN-wide group,
//              LSB group first, short group padded with 0
//   in/out_valid, in/out_mode : token valid and NOR/OR mode riding along
//   stall    : holds every register; rst clears them (rst wins)
// HOLD=1 is used on the last rank: data and mode only load on a valid token
// so the final result survives bubbles.
module nor_tree_level
   import rv523_cell_pkg::*;
#(
   parameter  int IN_W  = 3,
   parameter  int FANIN = 3,
   parameter  bit HOLD  = 1'b0,
   localparam int OUT_W = level_width(IN_W, FANIN, 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             in_valid,
   input  logic             in_mode,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   output logic             out_mode,
   output logic [OUT_W-1:0] out_data
);

   logic [OUT_W*FANIN-1:0] padded;
   logic [OUT_W-1:0]       grp_or;

   always_comb begin
      padded            = '0;
      padded[IN_W-1:0]  = in_data;
      grp_or            = '0;
      for (int g = 0; g < OUT_W; g++) begin
         grp_or[g] = |padded[g*FANIN +: FANIN];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         out_valid <= in_valid;
         if (!HOLD || in_valid) begin
            out_data <= grp_or;
            out_mode <= in_mode;
         end
      end
   end

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined wide NOR/OR reduction (zero-detect / flag-reduction unit).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : nor_tree_pipe_if.slave (in_valid, a, invert, stall -> out_valid, y)
// LEVELS ranks of FANIN-input OR groups; a token captured at edge n shows on
// out_valid/y after edge n+LEVELS-1. y = OR(a) ^ invert, with the mode bit
// applied once, after the last rank.
module nor_tree_pipe
   import rv523_cell_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FANIN = 3
) (
   input logic              clk,
   input logic              rst,
   nor_tree_pipe_if.slave   bus
);

   localparam int LEVELS  = clog_fanin(WIDTH, FANIN);
   // All levels 0..LEVELS packed back to back; level 0 is the input word.
   localparam int CHAIN_W = level_offset(WIDTH, FANIN, LEVELS + 1);
   localparam int Y_OFF   = level_offset(WIDTH, FANIN, LEVELS);

   logic [CHAIN_W-1:0] chain;
   logic [LEVELS:0]    valid_s;
   logic [LEVELS:0]    mode_s;

   assign chain[WIDTH-1:0] = bus.a;
   assign valid_s[0]       = bus.in_valid;
   assign mode_s[0]        = bus.invert;

   for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int IN_OFF  = level_offset(WIDTH, FANIN, k - 1);
      localparam int IN_W    = level_width(WIDTH, FANIN, k - 1);
      localparam int OUT_OFF = level_offset(WIDTH, FANIN, k);
      localparam int OUT_W   = level_width(WIDTH, FANIN, k);

      nor_tree_level #(
         .IN_W  (IN_W),
         .FANIN (FANIN),
         .HOLD  (k == LEVELS)
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .stall     (bus.stall),
         .in_valid  (valid_s[k-1]),
         .in_mode   (mode_s[k-1]),
         .in_data   (chain[IN_OFF +: IN_W]),
         .out_valid (valid_s[k]),
         .out_mode  (mode_s[k]),
         .out_data  (chain[OUT_OFF +: OUT_W])
      );
   end

   // Last rank holds one bit; both operands are registers that only load
   // on valid tokens, so y holds across bubbles and stalls.
   assign bus.out_valid = valid_s[LEVELS];
   assign bus.y         = chain[Y_OFF] ^ mode_s[LEVELS];

endmodule
